down_counter: RTL and testbench



---
 rtl/down_counter.sv | 100 ++++++++++
 tb/tb_down_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down-counting timer: valid/ready load, prescaled ticks on EN,
// one-cycle TC pulse on expiry with optional auto-reload of the last load.
module down_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             EN,
  input  logic             AUTO_RELOAD,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic             tick_c;

  // State and datapath registers; reset aborts any run without a TC.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      tc_q     <= tc_d;
    end
  end

  assign tick_c = (state_q == ST_RUN) && EN && (presc_q == PW'(PRESCALE - 1));

  // Next-state: load in IDLE, prescaled countdown in RUN.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    tc_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (LOAD_VALID) begin
          q_d      = LOAD_DATA;
          reload_d = LOAD_DATA;
          presc_d  = '0;
          if (LOAD_DATA != '0) begin
            state_d = ST_RUN;
          end else begin
            tc_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (EN) begin
          presc_d = tick_c ? '0 : PW'(presc_q + PW'(1));
        end
        if (tick_c) begin
          if (q_q > WIDTH'(1)) begin
            q_d = WIDTH'(q_q - WIDTH'(1));
          end else if (AUTO_RELOAD) begin
            // Prescaler keeps wrapping across a reload.
            q_d  = reload_q;
            tc_d = 1'b1;
          end else begin
            q_d     = '0;
            tc_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Q          = q_q;
  assign TC         = tc_q;
  assign BUSY       = (state_q == ST_RUN);
  assign LOAD_READY = (state_q == ST_IDLE);

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: one instance with PRESCALE=1, one with PRESCALE=3.
module tb_down_counter;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;

  logic [3:0] q1, q3;
  logic       tc1, tc3, busy1, busy3, ready1, ready3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .CLK(clk), .RES(res_n), .LOAD_VALID(load_valid), .LOAD_READY(ready1),
    .LOAD_DATA(load_data), .EN(en), .AUTO_RELOAD(auto_reload),
    .Q(q1), .TC(tc1), .BUSY(busy1)
  );

  down_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .CLK(clk), .RES(res_n), .LOAD_VALID(load_valid), .LOAD_READY(ready3),
    .LOAD_DATA(load_data), .EN(en), .AUTO_RELOAD(auto_reload),
    .Q(q3), .TC(tc3), .BUSY(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    en = 1'b0;
    auto_reload = 1'b0;
    step();
    step();
    res_n = 1'b1;
  endtask

  task automatic load(input logic [3:0] d);
    load_valid = 1'b1;
    load_data = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    res_n = 1'b0;
    step();
    checks++;
    if (q1 !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q1); end
    checks++;
    if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready1); end
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++;
    if (tc1 !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc1); end
    res_n = 1'b1;
  endtask

  task automatic test_count5();
    logic [3:0] exp_q;
    do_reset();
    en = 1'b1;
    load(4'd5);
    checks++;
    if (q1 !== 4'd5 || busy1 !== 1'b1 || ready1 !== 1'b0 || tc1 !== 1'b0) begin
      failures++;
      $display("FAIL count5_load q=%0d busy=%b ready=%b tc=%b exp q=5 busy=1 ready=0 tc=0",
               q1, busy1, ready1, tc1);
    end
    for (int e = 1; e <= 5; e++) begin
      step();
      exp_q = 4'(5 - e);
      checks++;
      if (q1 !== exp_q || tc1 !== (e == 5) || busy1 !== (e != 5) || ready1 !== (e == 5)) begin
        failures++;
        $display("FAIL count5_e%0d q=%0d tc=%b busy=%b ready=%b exp q=%0d tc=%b busy=%b ready=%b",
                 e, q1, tc1, busy1, ready1, exp_q, (e == 5), (e != 5), (e == 5));
      end
    end
    step();
    checks++;
    if (tc1 !== 1'b0 || q1 !== 4'd0) begin
      failures++; $display("FAIL count5_after tc=%b q=%0d exp tc=0 q=0", tc1, q1);
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp_q;
    do_reset();
    en = 1'b1;
    load(4'd2);
    checks++;
    if (q3 !== 4'd2) begin failures++; $display("FAIL presc_load got=%0d exp=2", q3); end
    // EN dropped for edges 5..8 pushes expiry from edge 6 to edge 10.
    for (int e = 1; e <= 10; e++) begin
      en = !(e >= 5 && e <= 8);
      step();
      exp_q = (e < 3) ? 4'd2 : ((e < 10) ? 4'd1 : 4'd0);
      checks++;
      if (q3 !== exp_q || tc3 !== (e == 10) || busy3 !== (e != 10)) begin
        failures++;
        $display("FAIL presc_e%0d q=%0d tc=%b busy=%b exp q=%0d tc=%b busy=%b",
                 e, q3, tc3, busy3, exp_q, (e == 10), (e != 10));
      end
    end
  endtask

  task automatic test_autoreload();
    logic [3:0] exp_tab [1:9];
    exp_tab = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd0};
    do_reset();
    en = 1'b1;
    auto_reload = 1'b1;
    load(4'd3);
    for (int e = 1; e <= 9; e++) begin
      auto_reload = (e <= 7);
      step();
      checks++;
      if (q1 !== exp_tab[e] || tc1 !== (e % 3 == 0) || busy1 !== (e != 9)) begin
        failures++;
        $display("FAIL autoreload_e%0d q=%0d tc=%b busy=%b exp q=%0d tc=%b busy=%b",
                 e, q1, tc1, busy1, exp_tab[e], (e % 3 == 0), (e != 9));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    auto_reload = 1'b1;
    load(4'd1);
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (q1 !== 4'd1 || tc1 !== 1'b1 || busy1 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_e%0d q=%0d tc=%b busy=%b exp q=1 tc=1 busy=1", e, q1, tc1, busy1);
      end
    end
  endtask

  task automatic test_handshake_zero();
    do_reset();
    en = 1'b1;
    load(4'd5);
    load_valid = 1'b1;
    load_data = 4'd9;
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++;
      if (q1 !== 4'(5 - e)) begin
        failures++; $display("FAIL ignore_load_e%0d got=%0d exp=%0d", e, q1, 5 - e);
      end
    end
    load_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (q1 !== 4'd0 || ready1 !== 1'b1) begin
      failures++; $display("FAIL drain q=%0d ready=%b exp q=0 ready=1", q1, ready1);
    end
    step();
    load(4'd0);
    checks++;
    if (q1 !== 4'd0 || tc1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
      failures++;
      $display("FAIL zero_load q=%0d tc=%b busy=%b ready=%b exp q=0 tc=1 busy=0 ready=1",
               q1, tc1, busy1, ready1);
    end
    step();
    checks++;
    if (tc1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL zero_load_after tc=%b busy=%b exp tc=0 busy=0", tc1, busy1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    load(4'd15);
    for (int e = 1; e <= 8; e++) step();
    checks++;
    if (q1 !== 4'd7) begin failures++; $display("FAIL async_pre got=%0d exp=7", q1); end
    #2;
    res_n = 1'b0;
    #1;
    checks++;
    if (q1 !== 4'd0 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
      failures++;
      $display("FAIL async_now q=%0d busy=%b ready=%b exp q=0 busy=0 ready=1", q1, busy1, ready1);
    end
    step();
    res_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if (tc1 !== 1'b0 || q1 !== 4'd0) begin
        failures++; $display("FAIL async_after_e%0d tc=%b q=%0d exp tc=0 q=0", e, tc1, q1);
      end
    end
  endtask

  task automatic test_wrap_max();
    do_reset();
    en = 1'b1;
    load(4'd15);
    for (int e = 1; e <= 14; e++) begin
      step();
      checks++;
      if (q1 !== 4'(15 - e) || tc1 !== 1'b0) begin
        failures++;
        $display("FAIL max_e%0d q=%0d tc=%b exp q=%0d tc=0", e, q1, tc1, 15 - e);
      end
    end
    load_valid = 1'b1;
    load_data = 4'd4;
    step();
    checks++;
    if (q1 !== 4'd0 || tc1 !== 1'b1 || ready1 !== 1'b1) begin
      failures++;
      $display("FAIL max_expiry q=%0d tc=%b ready=%b exp q=0 tc=1 ready=1", q1, tc1, ready1);
    end
    step();
    load_valid = 1'b0;
    checks++;
    if (q1 !== 4'd4 || tc1 !== 1'b0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL max_reload q=%0d tc=%b busy=%b exp q=4 tc=0 busy=1", q1, tc1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_count5();
    test_prescale();
    test_autoreload();
    test_back_to_back();
    test_handshake_zero();
    test_async_reset();
    test_wrap_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
